mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single 1-cycle-latency memory port.
// Define ARB_ROUND_ROBIN_EN for alternating conflict resolution; default is fixed priority with a fetch starvation limit.
module mem_port_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_gnt,
   output logic        o_if_rvalid,
   output logic [31:0] o_if_rdata,
   input  logic        i_ls_req,
   input  logic        i_ls_wren,
   input  logic [31:0] i_ls_addr,
   input  logic [31:0] i_ls_wdata,
   input  logic [3:0]  i_ls_bmask,
   output logic        o_ls_gnt,
   output logic        o_ls_rvalid,
   output logic [31:0] o_ls_rdata,
   output logic        o_mem_req,
   output logic        o_mem_wren,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_bmask,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RET_IF = 2'd1,
      RET_LS = 2'd2
   } state_t;

   state_t      state, next_state;
   logic        if_win;
   logic [31:0] if_rdata_q, ls_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = fetch won the most recent conflict
   logic rr_last_if;

   always_ff @(posedge i_clk) begin
      if (i_reset)
         rr_last_if <= 1'b1;
      else if (i_if_req && i_ls_req)
         rr_last_if <= o_if_gnt;
   end

   always_comb begin
      if_win = 1'b0;
      if (i_if_req)
         if_win = !i_ls_req || !rr_last_if;
   end
`else
   localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] wait_cnt;

   // Consecutive cycles fetch has been left waiting; saturates at MAX_WAIT
   always_ff @(posedge i_clk) begin
      if (i_reset || !i_if_req || o_if_gnt)
         wait_cnt <= '0;
      else if (wait_cnt != CNT_W'(MAX_WAIT))
         wait_cnt <= wait_cnt + CNT_W'(1);
   end

   always_comb begin
      if_win = 1'b0;
      if (i_if_req)
         if_win = !i_ls_req || (wait_cnt == CNT_W'(MAX_WAIT));
   end
`endif

   assign o_if_gnt  = !i_reset && if_win;
   assign o_ls_gnt  = !i_reset && i_ls_req && !if_win;

   // Memory port payload mux; zeroed when idle
   always_comb begin
      o_mem_req   = 1'b0;
      o_mem_wren  = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_bmask = '0;
      if (o_if_gnt) begin
         o_mem_req   = 1'b1;
         o_mem_addr  = i_if_addr;
         o_mem_bmask = 4'b1111;
      end else if (o_ls_gnt) begin
         o_mem_req   = 1'b1;
         o_mem_wren  = i_ls_wren;
         o_mem_addr  = i_ls_addr;
         o_mem_wdata = i_ls_wdata;
         o_mem_bmask = i_ls_bmask;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = IDLE;
      if (o_if_gnt)
         next_state = RET_IF;
      else if (o_ls_gnt && !i_ls_wren)
         next_state = RET_LS;
   end

   // Return strobes are masked during reset so an in-flight read is dropped
   always_comb begin
      o_if_rvalid = 1'b0;
      o_ls_rvalid = 1'b0;
      if (!i_reset) begin
         o_if_rvalid = (state == RET_IF);
         o_ls_rvalid = (state == RET_LS);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         if (o_if_rvalid) if_rdata_q <= i_mem_rdata;
         if (o_ls_rvalid) ls_rdata_q <= i_mem_rdata;
      end
   end

   assign o_if_rdata = o_if_rvalid ? i_mem_rdata : if_rdata_q;
   assign o_ls_rdata = o_ls_rvalid ? i_mem_rdata : ls_rdata_q;

endmodule
